shift_seq_unit: RTL and testbench

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

---
 rtl/shift_seq_unit.sv | 127 ++++++++++++
 tb/tb_shift_seq_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// Purpose: sequential 32-bit shifter (SLL / SRA), one binary-weighted stage per cycle.
// Latency: fixed 5 cycles from acceptance edge to out_valid, independent of shift amount.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   in_valid / in_ready     - operation handshake (data_operandA, ctrl_shiftamt, ctrl_sra)
//   out_valid / out_ready   - result handshake (data_result)
//   busy                    - high whenever the FSM is not in IDLE
module shift_seq_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    input  logic        ctrl_sra,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_work;
    logic [4:0]  r_shamt;
    logic        r_sra;
    logic        r_out_valid;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_sel;
    logic [4:0]  w_dist;
    logic [31:0] w_shifted;
    logic [31:0] w_stage;

    // Stage counter walks the shift amount MSB first: 16, 8, 4, 2, 1.
    always_comb begin
        w_sel  = 1'b0;
        w_dist = 5'd0;
        case (r_cnt)
            3'd0: begin w_sel = r_shamt[4]; w_dist = 5'd16; end
            3'd1: begin w_sel = r_shamt[3]; w_dist = 5'd8;  end
            3'd2: begin w_sel = r_shamt[2]; w_dist = 5'd4;  end
            3'd3: begin w_sel = r_shamt[1]; w_dist = 5'd2;  end
            3'd4: begin w_sel = r_shamt[0]; w_dist = 5'd1;  end
            default: begin w_sel = 1'b0; w_dist = 5'd0; end
        endcase
    end

    // Arithmetic right shift replicates the current bit 31 of the working register.
    always_comb begin
        w_shifted = 32'd0;
        if (r_sra) begin
            w_shifted = 32'($signed(r_work) >>> w_dist);
        end else begin
            w_shifted = r_work << w_dist;
        end
    end

    // Per-bit 2:1 mux: a stage whose shamt bit is clear passes the register through.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_stage_mux
            assign w_stage[gi] = w_sel ? w_shifted[gi] : r_work[gi];
        end
    endgenerate

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign data_result = r_result;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_work      <= 32'd0;
            r_shamt     <= 5'd0;
            r_sra       <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work  <= data_operandA;
                        r_shamt <= ctrl_shiftamt;
                        r_sra   <= ctrl_sra;
                        r_cnt   <= 3'd0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_stage;
                    if (r_cnt == 3'd4) begin
                        r_cnt       <= 3'd0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_stage;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here guarantees one idle cycle before the next accept.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_sra;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic        sra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    shift_seq_unit dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_sra      (ctrl_sra),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh, input logic sra);
        logic [31:0] r;
        if (sra) r = 32'($signed(a) >>> sh);
        else     r = a << sh;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents an op, checks it is accepted on the next edge, leaves time at E0+1.
    task automatic issue(input logic [31:0] a, input logic [4:0] sh, input logic sra, input logic [31:0] exp);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid      = 1'b1;
        data_operandA = a;
        ctrl_shiftamt = sh;
        ctrl_sra      = sra;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Waits (bounded) for out_valid, checks 5-edge latency and the result.
    task automatic wait_result(input string name);
        int cyc;
        logic [31:0] e;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({name, "_latency"}, cyc, 5);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: result with empty queue, got 0x%08h", name, data_result);
        end else begin
            e = exp_q.pop_front();
            check({name, "_data"}, data_result, e);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        tbl[0] = '{32'h00000001, 5'd4,  1'b0, 32'h00000010};
        tbl[1] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
        tbl[2] = '{32'h7FFFFFFF, 5'd4,  1'b1, 32'h07FFFFFF};
        tbl[3] = '{32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF};
        tbl[4] = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF};
        tbl[5] = '{32'h00000003, 5'd31, 1'b0, 32'h80000000};
        tbl[6] = '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000};
        tbl[7] = '{32'h12345678, 5'd13, 1'b0, 32'h8ACF0000};
        tbl[8] = '{32'hF0000000, 5'd5,  1'b1, 32'hFF800000};
        tbl[9] = '{32'hA5A5A5A5, 5'd21, 1'b1, 32'hFFFFFD2D};

        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        data_operandA = 32'd0;
        ctrl_shiftamt = 5'd0;
        ctrl_sra      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_result", data_result, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].a, tbl[i].sh, tbl[i].sra, tbl[i].exp);
            wait_result($sformatf("vec%0d", i));
            consume();
            tick();
        end

        // Randomized operations checked against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [4:0]  sh;
            logic        s;
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            s  = 1'($urandom_range(0, 1));
            issue(a, sh, s, model(a, sh, s));
            wait_result($sformatf("rnd%0d", i));
            consume();
            tick();
        end

        // Backpressure: result held 4 cycles while in_valid pulses are ignored.
        begin
            logic [31:0] held;
            issue(32'h0000ABCD, 5'd3, 1'b0, 32'h00055E68);
            wait_result("bp");
            held = data_result;
            for (int k = 0; k < 4; k++) begin
                in_valid      = k[0];
                data_operandA = 32'hFFFF0000 + k;
                ctrl_shiftamt = 5'd7;
                ctrl_sra      = 1'b1;
                tick();
                check($sformatf("bp_out_valid%0d", k), {31'd0, out_valid}, 32'd1);
                check($sformatf("bp_data%0d", k), data_result, 32'h00055E68);
                check($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
            consume();
            tick();
            check("bp_no_extra_accept", {31'd0, busy}, 32'd0);
            check("bp_no_extra_valid", {31'd0, out_valid}, 32'd0);
            check("bp_last_result_kept", data_result, held);
        end

        // Reset on the third SHIFT cycle discards the operation.
        begin
            int spurious;
            issue(32'h00000F0F, 5'd2, 1'b0, 32'h00003C3C);
            tick();
            tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            exp_q.delete();
            check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            check("midrst_data", data_result, 32'd0);
            check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
            check("midrst_busy", {31'd0, busy}, 32'd0);
            spurious = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (out_valid) spurious++;
            end
            check("midrst_no_spurious_valid", spurious, 0);
        end

        // Back-to-back: second op presented with out_ready waits one IDLE cycle.
        begin
            issue(32'h00000001, 5'd4, 1'b0, 32'h00000010);
            wait_result("b2b_first");
            out_ready     = 1'b1;
            in_valid      = 1'b1;
            data_operandA = 32'h0000F000;
            ctrl_shiftamt = 5'd8;
            ctrl_sra      = 1'b0;
            tick();
            out_ready = 1'b0;
            check("b2b_not_accepted_in_done", {31'd0, busy}, 32'd0);
            check("b2b_in_ready_idle", {31'd0, in_ready}, 32'd1);
            check("b2b_out_valid_dropped", {31'd0, out_valid}, 32'd0);
            exp_q.push_back(32'h00F00000);
            tick();
            in_valid = 1'b0;
            check("b2b_accepted", {31'd0, busy}, 32'd1);
            wait_result("b2b_second");
            consume();
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
